// File: rtl/mux_pkg.sv
// Select encodings shared by the 4:1 lane selector and its shift-register users.
package mux_pkg;

    localparam int NUM_LANES = 4;

    // Generic lane numbering.
    localparam logic [1:0] SEL_L0 = 2'd0;
    localparam logic [1:0] SEL_L1 = 2'd1;
    localparam logic [1:0] SEL_L2 = 2'd2;
    localparam logic [1:0] SEL_L3 = 2'd3;

    // The same codes as seen by the shift-register datapath.
    localparam logic [1:0] SEL_HOLD = SEL_L0;
    localparam logic [1:0] SEL_SHL  = SEL_L1;
    localparam logic [1:0] SEL_SHR  = SEL_L2;
    localparam logic [1:0] SEL_LOAD = SEL_L3;

endpackage

// File: rtl/mux_2to1.sv
// Two-input lane selector; a building block of the 4:1 tree.
module mux_2to1 #(
    parameter int DATA_W = 1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sel,
    output logic [DATA_W-1:0] y
);

    // Unknown select gives an unknown output instead of silently picking a lane.
    always_comb begin
        y = {DATA_W{1'bx}};
        case (sel)
            1'b0:    y = a;
            1'b1:    y = b;
            default: y = {DATA_W{1'bx}};
        endcase
    end

endmodule

// File: rtl/mux_4to1.sv
// Four-lane selector: combinational F plus an enabled, async-reset copy F_Q.
module mux_4to1
    import mux_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [NUM_LANES*DATA_W-1:0] W,
    input  logic [1:0]                  S,
    input  logic                        EN,
    output logic [DATA_W-1:0]           F,
    output logic [DATA_W-1:0]           F_Q
);

    logic [DATA_W-1:0] lo_pair;
    logic [DATA_W-1:0] hi_pair;
    logic [DATA_W-1:0] f_q_d;
    logic [DATA_W-1:0] f_q_q;

    // Level 1: S[0] picks within lanes 0/1 and lanes 2/3.
    mux_2to1 #(.DATA_W(DATA_W)) u_mux_lo (
        .a   (W[0*DATA_W +: DATA_W]),
        .b   (W[1*DATA_W +: DATA_W]),
        .sel (S[0]),
        .y   (lo_pair)
    );

    mux_2to1 #(.DATA_W(DATA_W)) u_mux_hi (
        .a   (W[2*DATA_W +: DATA_W]),
        .b   (W[3*DATA_W +: DATA_W]),
        .sel (S[0]),
        .y   (hi_pair)
    );

    // Level 2: S[1] picks between the two pairs.
    mux_2to1 #(.DATA_W(DATA_W)) u_mux_top (
        .a   (lo_pair),
        .b   (hi_pair),
        .sel (S[1]),
        .y   (F)
    );

    // Load the selected lane when enabled, otherwise hold.
    always_comb begin
        f_q_d = f_q_q;
        if (EN) begin
            f_q_d = F;
        end
    end

    // Registered copy; reset clears it immediately.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            f_q_q <= '0;
        end else begin
            f_q_q <= f_q_d;
        end
    end

    assign F_Q = f_q_q;

endmodule

// File: tb/tb_mux_4to1.sv
// Bench for mux_4to1 with a 1-bit and an 8-bit instance sharing clock and reset.
module tb_mux_4to1;

    logic       clk;
    logic       rst_n;

    logic [3:0] w1;
    logic [1:0] s1;
    logic       en1;
    logic [0:0] f1;
    logic [0:0] fq1;

    logic [31:0] w8;
    logic [1:0]  s8;
    logic        en8;
    logic [7:0]  f8;
    logic [7:0]  fq8;

    int tests_run;
    int tests_failed;

    mux_4to1 #(.DATA_W(1)) dut1 (
        .CLK   (clk),
        .RST_N (rst_n),
        .W     (w1),
        .S     (s1),
        .EN    (en1),
        .F     (f1),
        .F_Q   (fq1)
    );

    mux_4to1 #(.DATA_W(8)) dut8 (
        .CLK   (clk),
        .RST_N (rst_n),
        .W     (w8),
        .S     (s8),
        .EN    (en8),
        .F     (f8),
        .F_Q   (fq8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: lane s is the s-th DATA_W-wide slice counting from bit 0.
    function automatic logic ref_lane1(input logic [3:0] w, input logic [1:0] s);
        return (w >> s) & 4'd1;
    endfunction

    function automatic logic [7:0] ref_lane8(input logic [31:0] w, input logic [1:0] s);
        logic [31:0] sh;
        sh = w >> (32'(s) * 8);
        return sh[7:0];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        w1 = 4'b1111; s1 = 2'd0; en1 = 1'b1;
        w8 = 32'hFFFF_FFFF; s8 = 2'd1; en8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (fq1 !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_fq1 cyc%0d: got %b want 0", i, fq1);
            end
            tests_run++;
            if (f1 !== 1'b1) begin
                tests_failed++;
                $display("FAIL reset_f1 cyc%0d: got %b want 1", i, f1);
            end
            tests_run++;
            if (fq8 !== 8'h00) begin
                tests_failed++;
                $display("FAIL reset_fq8 cyc%0d: got %h want 00", i, fq8);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (fq1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_fq1: got %b want 1", fq1);
        end
        tests_run++;
        if (fq8 !== 8'hFF) begin
            tests_failed++;
            $display("FAIL reset_release_fq8: got %h want ff", fq8);
        end
    endtask

    task automatic test_exhaustive();
        logic exp_seq [8];
        logic [3:0] iv;
        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        en1 = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            iv = 4'(i);
            w1 = iv;
            s1 = iv[1:0];
            #10;
            tests_run++;
            if (f1 !== exp_seq[i]) begin
                tests_failed++;
                $display("FAIL exhaustive i=%0d: got %b want %b", i, f1, exp_seq[i]);
            end
        end
    endtask

    task automatic test_onehot();
        logic exp;
        for (int k = 0; k < 4; k++) begin
            w1 = 4'(1 << k);
            for (int s = 0; s < 4; s++) begin
                s1 = 2'(s);
                exp = (s == k);
                #2;
                tests_run++;
                if (f1 !== exp) begin
                    tests_failed++;
                    $display("FAIL onehot k=%0d s=%0d: got %b want %b", k, s, f1, exp);
                end
            end
        end
        w1 = 4'b1111;
        for (int s = 0; s < 4; s++) begin
            s1 = 2'(s);
            #2;
            tests_run++;
            if (f1 !== 1'b1) begin
                tests_failed++;
                $display("FAIL allones s=%0d: got %b want 1", s, f1);
            end
        end
    endtask

    task automatic test_enable();
        @(negedge clk);
        en1 = 1'b1; w1 = 4'b0100; s1 = 2'd2;
        @(negedge clk);
        tests_run++;
        if (fq1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL enable_load: got %b want 1", fq1);
        end
        en1 = 1'b0; w1 = 4'b0000;
        @(negedge clk);
        tests_run++;
        if (fq1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL enable_hold_fq: got %b want 1", fq1);
        end
        tests_run++;
        if (f1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL enable_hold_f: got %b want 0", f1);
        end
    endtask

    task automatic test_async_reset();
        // fq1 is 1 from the enable test; drop reset between edges.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (fq1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got %b want 0", fq1);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wide();
        logic [7:0] exp_f;
        w8 = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        en8 = 1'b1;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            s8 = 2'(s);
            exp_f = 8'hAA + 8'(s) * 8'h11;
            #1;
            tests_run++;
            if (f8 !== exp_f) begin
                tests_failed++;
                $display("FAIL wide_f s=%0d: got %h want %h", s, f8, exp_f);
            end
            @(negedge clk);
            tests_run++;
            if (fq8 !== exp_f) begin
                tests_failed++;
                $display("FAIL wide_fq s=%0d: got %h want %h", s, fq8, exp_f);
            end
        end
    endtask

    task automatic test_random();
        logic       exp_q1;
        logic [7:0] exp_q8;
        @(negedge clk);
        w1 = 4'($urandom); s1 = 2'($urandom); en1 = 1'b1;
        w8 = $urandom; s8 = 2'($urandom); en8 = 1'b1;
        exp_q1 = ref_lane1(w1, s1);
        exp_q8 = ref_lane8(w8, s8);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            tests_run++;
            if (fq1 !== exp_q1) begin
                tests_failed++;
                $display("FAIL rand_fq1 i=%0d: got %b want %b", i, fq1, exp_q1);
            end
            tests_run++;
            if (fq8 !== exp_q8) begin
                tests_failed++;
                $display("FAIL rand_fq8 i=%0d: got %h want %h", i, fq8, exp_q8);
            end
            w1 = 4'($urandom); s1 = 2'($urandom); en1 = 1'($urandom);
            w8 = $urandom; s8 = 2'($urandom); en8 = 1'($urandom);
            #1;
            tests_run++;
            if (f1 !== ref_lane1(w1, s1)) begin
                tests_failed++;
                $display("FAIL rand_f1 i=%0d: got %b want %b", i, f1, ref_lane1(w1, s1));
            end
            tests_run++;
            if (f8 !== ref_lane8(w8, s8)) begin
                tests_failed++;
                $display("FAIL rand_f8 i=%0d: got %h want %h", i, f8, ref_lane8(w8, s8));
            end
            if (en1) exp_q1 = ref_lane1(w1, s1);
            if (en8) exp_q8 = ref_lane8(w8, s8);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        w1 = '0; s1 = '0; en1 = 1'b0;
        w8 = '0; s8 = '0; en8 = 1'b0;
        test_reset();
        test_exhaustive();
        test_onehot();
        test_enable();
        test_async_reset();
        test_wide();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
